// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage bundle: next-PC mux inputs plus the PC, status and counter outputs.
interface pc_fetch_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      next_pc;
  logic             stall;
  logic             halt_req;
  logic [31:0]      pc;
  logic             pc_valid;
  logic             halted;
  logic             fault;
  logic [31:0]      fault_pc;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    output next_pc, stall, halt_req,
    input  pc, pc_valid, halted, fault, fault_pc, cycle_cnt, instret_cnt
  );

  modport slave (
    input  next_pc, stall, halt_req,
    output pc, pc_valid, halted, fault, fault_pc, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter register with boot cycle, stall, halt, misalignment trap
// and cycle/retired-instruction counters.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic           clk,
  input  logic           rst,
  pc_fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT,
    FAULT
  } state_t;

  state_t           state, state_n;
  logic [31:0]      pc_r, pc_n;
  logic [31:0]      fpc_r, fpc_n;
  logic [CNT_W-1:0] cyc_r, cyc_n;
  logic [CNT_W-1:0] ins_r, ins_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc_r  <= RESET_VEC;
      fpc_r <= '0;
      cyc_r <= '0;
      ins_r <= '0;
    end else begin
      state <= state_n;
      pc_r  <= pc_n;
      fpc_r <= fpc_n;
      cyc_r <= cyc_n;
      ins_r <= ins_n;
    end
  end

  // Halt outranks stall, and both outrank the alignment check, so a
  // misaligned next_pc only traps when it would really be loaded.
  always_comb begin
    state_n = state;
    pc_n    = pc_r;
    fpc_n   = fpc_r;
    cyc_n   = cyc_r;
    ins_n   = ins_r;
    case (state)
      BOOT: state_n = RUN;
      RUN: begin
        cyc_n = cyc_r + CNT_W'(1);
        if (bus.halt_req) begin
          ins_n   = ins_r + CNT_W'(1);
          state_n = HALT;
        end else if (bus.stall) begin
          pc_n = pc_r;
        end else if (bus.next_pc[1:0] != 2'b00) begin
          fpc_n   = bus.next_pc;
          state_n = FAULT;
        end else begin
          pc_n  = bus.next_pc;
          ins_n = ins_r + CNT_W'(1);
        end
      end
      default: state_n = state;
    endcase
  end

  assign bus.pc          = pc_r;
  assign bus.pc_valid    = (state == RUN);
  assign bus.halted      = (state == HALT);
  assign bus.fault       = (state == FAULT);
  assign bus.fault_pc    = fpc_r;
  assign bus.cycle_cnt   = cyc_r;
  assign bus.instret_cnt = ins_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios then random traffic, every
// cycle compared against a rule-level model of the fetch stage.
module tb_pc_fetch_ctrl;
  localparam int unsigned CW = 4;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_ctrl_if #(.CNT_W(CW)) bus ();

  pc_fetch_ctrl #(.RESET_VEC(RV), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Rule-level model: one flag per condition of the stage.
  bit          m_init  = 1'b0;
  bit          m_boot, m_run, m_halt, m_fault;
  logic [31:0] m_pc, m_fpc;
  logic [CW-1:0] m_cyc, m_ins;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1'b1;
      m_boot = 1'b1; m_run = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
      m_pc = RV; m_fpc = '0; m_cyc = '0; m_ins = '0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_run = 1'b1;
    end else if (m_run) begin
      m_cyc = m_cyc + 1;
      if (bus.halt_req) begin
        m_ins = m_ins + 1; m_run = 1'b0; m_halt = 1'b1;
      end else if (bus.stall) begin
        // pc holds
      end else if (bus.next_pc % 4 != 0) begin
        m_fpc = bus.next_pc; m_run = 1'b0; m_fault = 1'b1;
      end else begin
        m_pc = bus.next_pc; m_ins = m_ins + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      chk("pc",       bus.pc,                    m_pc);
      chk("pc_valid", 32'(bus.pc_valid),         32'(m_run));
      chk("halted",   32'(bus.halted),           32'(m_halt));
      chk("fault",    32'(bus.fault),            32'(m_fault));
      chk("fault_pc", bus.fault_pc,              m_fpc);
      chk("cycle",    32'(bus.cycle_cnt),        32'(m_cyc));
      chk("instret",  32'(bus.instret_cnt),      32'(m_ins));
    end
  end

  task automatic drive(input logic r, input logic [31:0] np, input logic st, input logic hr);
    rst = r; bus.next_pc = np; bus.stall = st; bus.halt_req = hr;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 32'h4, 1'b0, 1'b0);
    drive(1'b0, 32'h4, 1'b0, 1'b0); // BOOT edge
  endtask

  logic [31:0] rnd;
  int unsigned r;

  initial begin
    bus.next_pc = 32'h4; bus.stall = 1'b0; bus.halt_req = 1'b0;

    // Reset and boot
    drive(1'b1, 32'h4, 1'b0, 1'b0);
    drive(1'b1, 32'h4, 1'b0, 1'b0);
    chk("pin_rst_pc",    bus.pc, 32'h0);
    chk("pin_rst_valid", 32'(bus.pc_valid), 32'h0);
    drive(1'b0, 32'h4, 1'b0, 1'b0);
    chk("pin_boot_valid", 32'(bus.pc_valid), 32'h1);
    chk("pin_boot_pc",    bus.pc, 32'h0);
    drive(1'b0, 32'h4, 1'b0, 1'b0);
    chk("pin_first_pc",  bus.pc, 32'h4);
    chk("pin_first_ins", 32'(bus.instret_cnt), 32'h1);
    chk("pin_first_cyc", 32'(bus.cycle_cnt), 32'h1);

    // Stall at pc=8
    drive(1'b0, 32'h8, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'hC, 1'b1, 1'b0);
    chk("pin_stall_pc",  bus.pc, 32'h8);
    chk("pin_stall_cyc", 32'(bus.cycle_cnt), 32'h5);
    drive(1'b0, 32'hC, 1'b0, 1'b0);
    chk("pin_unstall_pc", bus.pc, 32'hC);

    // Sequential run up to pc=40 from a fresh boot
    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b0, m_pc + 32'h4, 1'b0, 1'b0);
    chk("pin_seq_pc",  bus.pc, 32'd40);
    chk("pin_seq_ins", 32'(bus.instret_cnt), 32'd10);
    chk("pin_seq_cyc", 32'(bus.cycle_cnt), 32'd10);

    // Jump then misaligned target
    drive(1'b0, 32'h100, 1'b0, 1'b0);
    drive(1'b0, 32'h102, 1'b0, 1'b0);
    chk("pin_fault",    32'(bus.fault), 32'h1);
    chk("pin_fault_pc", bus.fault_pc, 32'h102);
    chk("pin_fault_hold", bus.pc, 32'h100);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h200, 1'b0, 1'b1);

    // Reset from FAULT, address wrap, and stall masking a misaligned target
    do_reset();
    drive(1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0);
    drive(1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
    drive(1'b0, m_pc + 32'h4, 1'b0, 1'b0);
    chk("pin_wrap_pc", bus.pc, 32'h0);

    // Halt outranks stall and misalignment
    drive(1'b0, 32'h3, 1'b1, 1'b1);
    chk("pin_halt",    32'(bus.halted), 32'h1);
    chk("pin_nofault", 32'(bus.fault), 32'h0);
    for (int i = 0; i < 5; i++) begin
      rnd = $urandom;
      drive(1'b0, rnd, 1'($urandom), 1'($urandom));
    end

    // Reset from HALT, then reset in RUN under stall
    do_reset();
    drive(1'b0, 32'h8, 1'b0, 1'b0);
    drive(1'b1, 32'h3, 1'b1, 1'b0);
    chk("pin_rst_run_pc", bus.pc, RV);
    drive(1'b0, 32'h4, 1'b0, 1'b0);
    chk("pin_reboot_valid", 32'(bus.pc_valid), 32'h1);

    // Random traffic; counters in CW bits exercise wrap
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      rnd = $urandom;
      if (r < 70)      rnd = m_pc + 32'h4;
      else if (r < 85) rnd[1:0] = 2'b00;
      else if (r < 90) rnd = 32'hFFFF_FFFC;
      if ((m_halt || m_fault) && $urandom_range(0, 9) == 0)
        drive(1'b1, rnd, 1'b0, 1'b0);
      else
        drive($urandom_range(0, 99) == 0, rnd,
              $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
